// File: rtl/fsd_scan_decoder.sv
// Passive decoder for a scanned fourteen-segment display bus: recovers each digit's ASCII
// character and decimal point by searching candidates through a reference segment encoder.

module fsd_one_digit_encoder (
    input  logic [7:0]  ascii,
    input  logic        dp_in,
    output logic [14:0] seg
);
    logic [7:0]  folded;
    logic [13:0] pattern;

    // Segment bits: a,b,c,d,e,f,g1,g2,h,i,j,k,l,m from bit 0; lowercase shares the uppercase glyph
    always_comb begin
        folded  = (ascii >= 8'h61 && ascii <= 8'h7A) ? ascii - 8'h20 : ascii;
        pattern = 14'h0000;
        case (folded)
            8'h21: pattern = 14'h0206;
            8'h22: pattern = 14'h0220;
            8'h23: pattern = 14'h12CE;
            8'h24: pattern = 14'h12ED;
            8'h25: pattern = 14'h0C24;
            8'h26: pattern = 14'h235D;
            8'h27: pattern = 14'h0200;
            8'h28: pattern = 14'h2400;
            8'h29: pattern = 14'h0900;
            8'h2A: pattern = 14'h3FC0;
            8'h2B: pattern = 14'h12C0;
            8'h2C: pattern = 14'h0800;
            8'h2D: pattern = 14'h00C0;
            8'h2F: pattern = 14'h0C00;
            8'h30: pattern = 14'h0C3F;
            8'h31: pattern = 14'h0406;
            8'h32: pattern = 14'h00DB;
            8'h33: pattern = 14'h008F;
            8'h34: pattern = 14'h00E6;
            8'h35: pattern = 14'h2069;
            8'h36: pattern = 14'h00FD;
            8'h37: pattern = 14'h0007;
            8'h38: pattern = 14'h00FF;
            8'h39: pattern = 14'h00EF;
            8'h3A: pattern = 14'h1200;
            8'h3B: pattern = 14'h0A00;
            8'h3C: pattern = 14'h2400;
            8'h3D: pattern = 14'h00C8;
            8'h3E: pattern = 14'h0900;
            8'h3F: pattern = 14'h1083;
            8'h40: pattern = 14'h02BB;
            8'h41: pattern = 14'h00F7;
            8'h42: pattern = 14'h128F;
            8'h43: pattern = 14'h0039;
            8'h44: pattern = 14'h120F;
            8'h45: pattern = 14'h00F9;
            8'h46: pattern = 14'h0071;
            8'h47: pattern = 14'h00BD;
            8'h48: pattern = 14'h00F6;
            8'h49: pattern = 14'h1209;
            8'h4A: pattern = 14'h001E;
            8'h4B: pattern = 14'h2470;
            8'h4C: pattern = 14'h0038;
            8'h4D: pattern = 14'h0536;
            8'h4E: pattern = 14'h2136;
            8'h4F: pattern = 14'h003F;
            8'h50: pattern = 14'h00F3;
            8'h51: pattern = 14'h203F;
            8'h52: pattern = 14'h20F3;
            8'h53: pattern = 14'h018D;
            8'h54: pattern = 14'h1201;
            8'h55: pattern = 14'h003E;
            8'h56: pattern = 14'h0C30;
            8'h57: pattern = 14'h2836;
            8'h58: pattern = 14'h2D00;
            8'h59: pattern = 14'h1500;
            8'h5A: pattern = 14'h0C09;
            8'h5B: pattern = 14'h0039;
            8'h5C: pattern = 14'h2100;
            8'h5D: pattern = 14'h000F;
            8'h5E: pattern = 14'h2800;
            8'h5F: pattern = 14'h0008;
            8'h60: pattern = 14'h0100;
            8'h7B: pattern = 14'h0949;
            8'h7C: pattern = 14'h1200;
            8'h7D: pattern = 14'h2489;
            8'h7E: pattern = 14'h0CC0;
            default: pattern = 14'h0000;
        endcase
        seg = {dp_in, pattern};
    end
endmodule

module fsd_scan_decoder #(
    parameter int DIGIT_COUNT     = 4,
    parameter int DIGIT_IDX_W     = 2,
    parameter int SEGMENT_COUNT   = 15,
    parameter int ASCII_BIT_WIDTH = 8,
    parameter int SETTLE_CYCLES   = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [SEGMENT_COUNT-1:0]             seg,
    input  logic [DIGIT_COUNT-1:0]               dig,
    output logic [DIGIT_COUNT*ASCII_BIT_WIDTH-1:0] chars,
    output logic [DIGIT_COUNT-1:0]               dp,
    output logic [DIGIT_COUNT-1:0]               unknown,
    output logic                                 frame_valid,
    output logic                                 scan_error
);
    localparam int SAMP_W = DIGIT_COUNT + SEGMENT_COUNT;
    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ASCII_BIT_WIDTH-1:0] CH_SPACE = ASCII_BIT_WIDTH'(8'h20);
    localparam logic [ASCII_BIT_WIDTH-1:0] CH_QMARK = ASCII_BIT_WIDTH'(8'h3F);
    localparam logic [ASCII_BIT_WIDTH-1:0] CH_LAST  = ASCII_BIT_WIDTH'(8'h7E);

    typedef enum logic [1:0] {IDLE, SEARCH, STORE, WAIT} state_t;

    state_t                     state, state_nxt;
    logic [SAMP_W-1:0]          samp_p0;
    logic [SAMP_W-1:0]          lat_p1;
    logic [CNT_W-1:0]           settle_cnt;
    logic [DIGIT_IDX_W-1:0]     lat_idx;
    logic [ASCII_BIT_WIDTH-1:0] cand;
    logic                       miss;
    logic [DIGIT_COUNT-1:0]     mask;

    logic                       stable, one_hot, blank, changed, enc_match, frame_done;
    logic [DIGIT_COUNT-1:0]     dig_low, store_bit;
    logic [DIGIT_IDX_W-1:0]     low_idx;
    logic [14:0]                enc_seg;
    logic                       latch_en, cand_inc, miss_set, store_en, set_err;

    // Stage p0: raw bus sample and settle counter
    always_ff @(posedge clk) begin
        samp_p0 <= {dig, seg};
        if (reset) begin
            settle_cnt <= '0;
        end else if ({dig, seg} != samp_p0) begin
            settle_cnt <= '0;
        end else if (settle_cnt != CNT_W'(SETTLE_CYCLES)) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        stable  = (settle_cnt == CNT_W'(SETTLE_CYCLES));
        dig_low = ~samp_p0[SAMP_W-1 -: DIGIT_COUNT];
        low_idx = '0;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            if (dig_low[i]) low_idx = DIGIT_IDX_W'(i);
        end
        blank      = (dig_low == '0);
        one_hot    = !blank && ((dig_low & (dig_low - DIGIT_COUNT'(1))) == '0);
        changed    = (samp_p0 != lat_p1);
        store_bit  = DIGIT_COUNT'(1) << lat_idx;
        frame_done = ((mask | store_bit) == {DIGIT_COUNT{1'b1}});
    end

    fsd_one_digit_encoder u_enc (
        .ascii (cand),
        .dp_in (1'b0),
        .seg   (enc_seg)
    );

    assign enc_match = (enc_seg == {1'b0, lat_p1[SEGMENT_COUNT-2:0]});

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        cand_inc  = 1'b0;
        miss_set  = 1'b0;
        store_en  = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (stable && one_hot) begin
                    latch_en  = 1'b1;
                    state_nxt = SEARCH;
                end else if (stable && !blank) begin
                    latch_en  = 1'b1;
                    set_err   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            SEARCH: begin
                if (changed) begin
                    state_nxt = IDLE;
                end else if (enc_match) begin
                    state_nxt = STORE;
                end else if (cand == CH_LAST) begin
                    miss_set  = 1'b1;
                    state_nxt = STORE;
                end else begin
                    cand_inc = 1'b1;
                end
            end
            STORE: begin
                store_en  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (changed) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: latched pattern and candidate under search
    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_p1  <= samp_p0;
            lat_idx <= low_idx;
            cand    <= CH_SPACE;
            miss    <= 1'b0;
        end else if (miss_set) begin
            cand <= CH_QMARK;
            miss <= 1'b1;
        end else if (cand_inc) begin
            cand <= cand + ASCII_BIT_WIDTH'(1);
        end
    end

    // Stage p2: per-digit results and frame tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            chars       <= {DIGIT_COUNT{CH_SPACE}};
            dp          <= '0;
            unknown     <= '0;
            mask        <= '0;
            frame_valid <= 1'b0;
            scan_error  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (set_err) scan_error <= 1'b1;
            if (store_en) begin
                chars[lat_idx*ASCII_BIT_WIDTH +: ASCII_BIT_WIDTH] <= cand;
                dp[lat_idx]      <= lat_p1[SEGMENT_COUNT-1];
                unknown[lat_idx] <= miss;
                if (frame_done) begin
                    frame_valid <= 1'b1;
                    mask        <= '0;
                end else begin
                    mask <= mask | store_bit;
                end
            end
        end
    end
endmodule

// File: tb/tb_fsd_scan_decoder.sv
// Randomized scoreboard bench for fsd_scan_decoder with a lowest-match font-lookup reference model.

module tb_fsd_scan_decoder;
    localparam int HOLD = 120;
    localparam int GAP  = 6;

    localparam logic [13:0] FONT [0:64] = '{
        14'h0000, 14'h0206, 14'h0220, 14'h12CE, 14'h12ED, 14'h0C24, 14'h235D, 14'h0200,
        14'h2400, 14'h0900, 14'h3FC0, 14'h12C0, 14'h0800, 14'h00C0, 14'h0000, 14'h0C00,
        14'h0C3F, 14'h0406, 14'h00DB, 14'h008F, 14'h00E6, 14'h2069, 14'h00FD, 14'h0007,
        14'h00FF, 14'h00EF, 14'h1200, 14'h0A00, 14'h2400, 14'h00C8, 14'h0900, 14'h1083,
        14'h02BB, 14'h00F7, 14'h128F, 14'h0039, 14'h120F, 14'h00F9, 14'h0071, 14'h00BD,
        14'h00F6, 14'h1209, 14'h001E, 14'h2470, 14'h0038, 14'h0536, 14'h2136, 14'h003F,
        14'h00F3, 14'h203F, 14'h20F3, 14'h018D, 14'h1201, 14'h003E, 14'h0C30, 14'h2836,
        14'h2D00, 14'h1500, 14'h0C09, 14'h0039, 14'h2100, 14'h000F, 14'h2800, 14'h0008,
        14'h0100
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] seg;
    logic [3:0]  dig;
    logic [31:0] chars;
    logic [3:0]  dp;
    logic [3:0]  unknown;
    logic        frame_valid;
    logic        scan_error;

    fsd_scan_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .dig         (dig),
        .chars       (chars),
        .dp          (dp),
        .unknown     (unknown),
        .frame_valid (frame_valid),
        .scan_error  (scan_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        logic [31:0] chars;
        logic [3:0]  dp;
        logic [3:0]  unk;
        logic        err;
        int          frames;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   frames_seen = 0;
    logic prev_fv = 1'b0;

    logic [7:0] m_chars [4];
    logic [3:0] m_dp, m_unk, m_mask;
    logic       m_err;
    int         m_frames = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    // Monitor: counts frame pulses and checks every due scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                frames_seen++;
                chk("frame_width", {31'b0, prev_fv}, 32'd0);
            end
            prev_fv = frame_valid;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk({e.name, ".chars"}, chars, e.chars);
                chk({e.name, ".dp"}, {28'b0, dp}, {28'b0, e.dp});
                chk({e.name, ".unknown"}, {28'b0, unknown}, {28'b0, e.unk});
                chk({e.name, ".scan_error"}, {31'b0, scan_error}, {31'b0, e.err});
                chk({e.name, ".frames"}, frames_seen, e.frames);
            end
        end
    end

    function automatic logic [13:0] font_of(logic [7:0] c);
        logic [7:0] f;
        f = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (f >= 8'h20 && f <= 8'h60) return FONT[f - 8'h20];
        case (f)
            8'h7B: return 14'h0949;
            8'h7C: return 14'h1200;
            8'h7D: return 14'h2489;
            8'h7E: return 14'h0CC0;
            default: return 14'h0000;
        endcase
    endfunction

    // Lowest printable character whose glyph equals the pattern; k = candidates stepped
    task automatic decode(input logic [13:0] pat, output logic [7:0] ch, output logic unk, output int k);
        ch = 8'h3F;
        unk = 1'b1;
        k = 94;
        for (int c = 8'h20; c <= 8'h7E; c++) begin
            if (font_of(8'(c)) == pat) begin
                ch = 8'(c);
                unk = 1'b0;
                k = c - 8'h20;
                break;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_chars[i] = 8'h20;
        m_dp = 4'b0;
        m_unk = 4'b0;
        m_mask = 4'b0;
        m_err = 1'b0;
    endtask

    task automatic push(input string name, input int due);
        exp_t e;
        e.due    = due;
        e.name   = name;
        e.chars  = {m_chars[3], m_chars[2], m_chars[1], m_chars[0]};
        e.dp     = m_dp;
        e.unk    = m_unk;
        e.err    = m_err;
        e.frames = m_frames;
        sbq.push_back(e);
    endtask

    task automatic blank_gap(input int n);
        dig = 4'hF;
        seg = 15'h0;
        repeat (n) @(negedge clk);
    endtask

    task automatic raw(input logic [3:0] d, input logic [14:0] s, input int hold, input int gap);
        @(negedge clk);
        dig = d;
        seg = s;
        repeat (hold) @(negedge clk);
        blank_gap(gap);
    endtask

    task automatic digit(input int idx, input logic [13:0] pat, input logic dpb, input string name);
        logic [7:0] ch;
        logic       unk;
        int         k;
        decode(pat, ch, unk, k);
        m_chars[idx] = ch;
        m_dp[idx]    = dpb;
        m_unk[idx]   = unk;
        m_mask[idx]  = 1'b1;
        if (m_mask == 4'hF) begin
            m_frames++;
            m_mask = 4'b0;
        end
        @(negedge clk);
        dig = ~(4'b0001 << idx);
        seg = {dpb, pat};
        push(name, cyc + k + 12);
        repeat (HOLD) @(negedge clk);
        blank_gap(GAP);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        push(name, cyc + 1);
        @(negedge clk);
        reset = 1'b0;
        blank_gap(GAP);
    endtask

    initial begin
        logic [13:0] pat;
        int          budget;
        reset = 1'b1;
        dig   = 4'hF;
        seg   = 15'h0;
        model_reset();
        repeat (3) @(negedge clk);
        push("reset", cyc);
        @(negedge clk);
        reset = 1'b0;
        blank_gap(GAP);

        digit(0, font_of("A"), 1'b1, "single_A");

        do_reset("reset2");
        digit(0, font_of("A"), 1'b0, "scan_A");
        digit(1, font_of("B"), 1'b0, "scan_B");
        digit(2, font_of("1"), 1'b1, "scan_1");
        digit(3, font_of("2"), 1'b0, "scan_2");

        digit(1, 14'h3FFF, 1'b0, "miss");

        m_err = 1'b1;
        push("scan_err", cyc + 40);
        raw(4'b1100, {1'b0, font_of("E")}, 40, GAP);
        digit(0, font_of("7"), 1'b0, "err_sticky");

        push("glitch", cyc + 20);
        raw(4'b1011, {1'b0, font_of("Z")}, 2, 20);
        push("abort", cyc + 90);
        raw(4'b1011, {1'b0, font_of("Z")}, 20, 90);

        do_reset("reset3");
        digit(0, font_of("Q"), 1'b0, "pre_0");
        digit(1, font_of("R"), 1'b1, "pre_1");
        digit(2, font_of("S"), 1'b0, "pre_2");
        @(negedge clk);
        dig = 4'b0111;
        seg = {1'b0, font_of("W")};
        repeat (20) @(negedge clk);
        reset = 1'b1;
        model_reset();
        push("reset_mid", cyc + 1);
        @(negedge clk);
        reset = 1'b0;
        blank_gap(GAP);
        digit(3, font_of("W"), 1'b0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 8) pat = font_of(8'($urandom_range(32, 126)));
            else                          pat = 14'($urandom);
            digit($urandom_range(0, 3), pat, 1'($urandom), "rand");
        end

        budget = 300;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sbq.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
